// File: rtl/fp_extract_pipe.sv
// fp_extract_pipe
// Pipelined operand extractor for the FP add/sub datapath. Each lane (one
// fp64 or two packed fp32) is ordered by magnitude, then unpacked into
// sign / exponent / fraction-with-hidden-bit, exponent difference and
// optional class flags.
//
// Optional feature macro: FP_EXTRACT_CLASS_EN
//   defined   -> class detection and class output registers are built
//   undefined -> o_class_l / o_class_s are tied to 0
//
// Handshake: a transfer happens on a rising edge when valid and ready are
// both high on that side. Ready never depends on valid of the same side.
// o_ready is a combinational chain from i_ready. A stage loads when it is
// empty or when its contents leave in the same cycle. Outputs hold while
// o_valid && !i_ready.
//
// Stage split: stage 0 registers the compared/swapped operands, middle
// stages delay them, and the last stage registers the unpacked results.
// With PIPE_DEPTH = 1 the whole computation feeds the output registers.
// PIPE_DEPTH is intended to be 1..4.
module fp_extract_pipe #(
  parameter int PIPE_DEPTH = 2,
  parameter int TAG_W      = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_mode,
  input  logic [63:0]       i_A,
  input  logic [63:0]       i_B,
  input  logic [TAG_W-1:0]  i_tag,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [15:0]       o_large_exp,
  output logic [15:0]       o_small_exp,
  output logic [15:0]       o_exp_diff,
  output logic [52:0]       o_large_frac53,
  output logic [52:0]       o_small_frac53,
  output logic [1:0]        o_Ls,
  output logic [1:0]        o_op,
  output logic [1:0]        o_swap,
  output logic [7:0]        o_class_l,
  output logic [7:0]        o_class_s,
  output logic [TAG_W-1:0]  o_tag
);

  // Swapped payload: {mode, large[63:0], small[62:0], swap, op, tag}.
  // The small operand's top sign bit is never needed after the swap.
  localparam int P_W = 132 + TAG_W;

  function automatic logic [10:0] eff11(input logic [10:0] e);
    return (e == 11'd0) ? 11'd1 : e;
  endfunction

  function automatic logic [7:0] eff8(input logic [7:0] e);
    return (e == 8'd0) ? 8'd1 : e;
  endfunction

  // ---------------------------------------------------------------------
  // Stage 1: magnitude compare and swap
  // ---------------------------------------------------------------------
  logic              a_gt64, b_gt64;
  logic [1:0]        a_gt32, b_gt32;
  logic [63:0]       s1_l;
  logic [62:0]       s1_s;
  logic [1:0]        s1_swap, s1_op;
  logic [P_W-1:0]    swapped_in;

  assign a_gt64    = i_A[62:0] > i_B[62:0];
  assign b_gt64    = i_B[62:0] > i_A[62:0];
  assign a_gt32[0] = i_A[30:0] > i_B[30:0];
  assign b_gt32[0] = i_B[30:0] > i_A[30:0];
  assign a_gt32[1] = i_A[62:32] > i_B[62:32];
  assign b_gt32[1] = i_B[62:32] > i_A[62:32];

  // Order each lane: A is large only when strictly bigger, ties pick B.
  always_comb begin
    s1_l    = '0;
    s1_s    = '0;
    s1_swap = '0;
    s1_op   = '0;
    if (i_mode) begin
      s1_l    = a_gt64 ? i_A : i_B;
      s1_s    = a_gt64 ? i_B[62:0] : i_A[62:0];
      s1_swap = {2{b_gt64}};
      s1_op   = {2{i_A[63] ^ i_B[63]}};
    end else begin
      s1_l[63:32] = a_gt32[1] ? i_A[63:32] : i_B[63:32];
      s1_l[31:0]  = a_gt32[0] ? i_A[31:0]  : i_B[31:0];
      s1_s[62:32] = a_gt32[1] ? i_B[62:32] : i_A[62:32];
      s1_s[31:0]  = a_gt32[0] ? i_B[31:0]  : i_A[31:0];
      s1_swap     = b_gt32;
      s1_op       = {i_A[63] ^ i_B[63], i_A[31] ^ i_B[31]};
    end
  end

  assign swapped_in = {i_mode, s1_l, s1_s, s1_swap, s1_op, i_tag};

  // ---------------------------------------------------------------------
  // Pipeline control
  // ---------------------------------------------------------------------
  logic [PIPE_DEPTH-1:0] valid_q;
  logic [PIPE_DEPTH-1:0] advance;
  logic [PIPE_DEPTH-1:0] stage_open;
  logic [PIPE_DEPTH-1:0] in_valid;
  logic [PIPE_DEPTH-1:0] stage_load;

  // Walk from the output back: a stage can take new data if it is empty
  // or if everything downstream of it can move.
  always_comb begin
    logic room;
    room       = i_ready;
    advance    = '0;
    stage_open = '0;
    for (int i = PIPE_DEPTH - 1; i >= 0; i--) begin
      advance[i]    = valid_q[i] & room;
      stage_open[i] = ~valid_q[i] | room;
      room          = stage_open[i];
    end
  end

  // Each stage's incoming valid is the input or the previous stage leaving.
  always_comb begin
    in_valid    = '0;
    in_valid[0] = i_valid;
    for (int i = 1; i < PIPE_DEPTH; i++) begin
      in_valid[i] = advance[i-1];
    end
  end

  assign stage_load = stage_open & in_valid;
  assign o_ready    = stage_open[0];
  assign o_valid    = valid_q[PIPE_DEPTH-1];

  // Valid bits: refresh whenever the stage is open.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        if (stage_open[i]) valid_q[i] <= in_valid[i];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Swapped-operand stages ahead of the output stage
  // ---------------------------------------------------------------------
  logic [P_W-1:0] final_src;

  if (PIPE_DEPTH > 1) begin : g_mid
    logic [P_W-1:0] mid_q [PIPE_DEPTH-1];

    // Carry the swapped payload forward one stage per load.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        for (int i = 0; i < PIPE_DEPTH - 1; i++) mid_q[i] <= '0;
      end else begin
        if (stage_load[0]) mid_q[0] <= swapped_in;
        for (int i = 1; i < PIPE_DEPTH - 1; i++) begin
          if (stage_load[i]) mid_q[i] <= mid_q[i-1];
        end
      end
    end

    assign final_src = mid_q[PIPE_DEPTH-2];
  end else begin : g_nomid
    assign final_src = swapped_in;
  end

  // ---------------------------------------------------------------------
  // Last stage: unpack
  // ---------------------------------------------------------------------
  logic              fin_mode;
  logic [63:0]       fin_l;
  logic [62:0]       fin_s;
  logic [1:0]        fin_swap, fin_op;
  logic [TAG_W-1:0]  fin_tag;

  assign fin_mode = final_src[P_W-1];
  assign fin_l    = final_src[P_W-2 -: 64];
  assign fin_s    = final_src[P_W-66 -: 63];
  assign fin_swap = final_src[TAG_W+3 -: 2];
  assign fin_op   = final_src[TAG_W+1 -: 2];
  assign fin_tag  = final_src[TAG_W-1:0];

  logic [15:0] nx_lexp, nx_sexp, nx_diff;
  logic [52:0] nx_lfrac, nx_sfrac;
  logic [1:0]  nx_ls;

  // Split exponent/fraction, insert hidden bits and form the difference.
  always_comb begin
    nx_lexp  = '0;
    nx_sexp  = '0;
    nx_diff  = '0;
    nx_lfrac = '0;
    nx_sfrac = '0;
    nx_ls    = '0;
    if (fin_mode) begin
      nx_lexp[10:0] = fin_l[62:52];
      nx_sexp[10:0] = fin_s[62:52];
      nx_diff[10:0] = eff11(fin_l[62:52]) - eff11(fin_s[62:52]);
      nx_lfrac      = {|fin_l[62:52], fin_l[51:0]};
      nx_sfrac      = {|fin_s[62:52], fin_s[51:0]};
      nx_ls         = {2{fin_l[63]}};
    end else begin
      nx_lexp         = {fin_l[62:55], fin_l[30:23]};
      nx_sexp         = {fin_s[62:55], fin_s[30:23]};
      nx_diff[7:0]    = eff8(fin_l[30:23]) - eff8(fin_s[30:23]);
      nx_diff[15:8]   = eff8(fin_l[62:55]) - eff8(fin_s[62:55]);
      nx_lfrac[23:0]  = {|fin_l[30:23], fin_l[22:0]};
      nx_lfrac[52:29] = {|fin_l[62:55], fin_l[54:32]};
      nx_sfrac[23:0]  = {|fin_s[30:23], fin_s[22:0]};
      nx_sfrac[52:29] = {|fin_s[62:55], fin_s[54:32]};
      nx_ls           = {fin_l[63], fin_l[31]};
    end
  end

  // Output registers update only when the last stage loads.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_large_exp    <= '0;
      o_small_exp    <= '0;
      o_exp_diff     <= '0;
      o_large_frac53 <= '0;
      o_small_frac53 <= '0;
      o_Ls           <= '0;
      o_op           <= '0;
      o_swap         <= '0;
      o_tag          <= '0;
    end else if (stage_load[PIPE_DEPTH-1]) begin
      o_large_exp    <= nx_lexp;
      o_small_exp    <= nx_sexp;
      o_exp_diff     <= nx_diff;
      o_large_frac53 <= nx_lfrac;
      o_small_frac53 <= nx_sfrac;
      o_Ls           <= nx_ls;
      o_op           <= fin_op;
      o_swap         <= fin_swap;
      o_tag          <= fin_tag;
    end
  end

`ifdef FP_EXTRACT_CLASS_EN
  // Class nibble order is {nan, inf, zero, subnormal}.
  function automatic logic [3:0] class_of(input logic e_ones, input logic e_zero,
                                          input logic f_nz);
    return {e_ones & f_nz, e_ones & ~f_nz, e_zero & ~f_nz, e_zero & f_nz};
  endfunction

  logic [7:0] nx_cl, nx_cs;

  // Classify both ordered operands; fp64 duplicates its nibble.
  always_comb begin
    nx_cl = '0;
    nx_cs = '0;
    if (fin_mode) begin
      nx_cl = {2{class_of(&fin_l[62:52], ~|fin_l[62:52], |fin_l[51:0])}};
      nx_cs = {2{class_of(&fin_s[62:52], ~|fin_s[62:52], |fin_s[51:0])}};
    end else begin
      nx_cl = {class_of(&fin_l[62:55], ~|fin_l[62:55], |fin_l[54:32]),
               class_of(&fin_l[30:23], ~|fin_l[30:23], |fin_l[22:0])};
      nx_cs = {class_of(&fin_s[62:55], ~|fin_s[62:55], |fin_s[54:32]),
               class_of(&fin_s[30:23], ~|fin_s[30:23], |fin_s[22:0])};
    end
  end

  // Class registers follow the same load enable as the other outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_class_l <= '0;
      o_class_s <= '0;
    end else if (stage_load[PIPE_DEPTH-1]) begin
      o_class_l <= nx_cl;
      o_class_s <= nx_cs;
    end
  end
`else
  assign o_class_l = '0;
  assign o_class_s = '0;
`endif

endmodule

// File: tb/tb_fp_extract_pipe.sv
// Directed bench for fp_extract_pipe: reset state, latency, hand-computed
// vectors in both modes, backpressure and reset in flight.
`timescale 1ns/1ps
module tb_fp_extract_pipe;

  localparam int DEPTH = 2;
  localparam int TAG_W = 4;
  localparam int BW    = 176 + TAG_W;
`ifdef FP_EXTRACT_CLASS_EN
  localparam bit CLASS_EN = 1'b1;
`else
  localparam bit CLASS_EN = 1'b0;
`endif

  logic              i_clk;
  logic              i_rst_n;
  logic              i_valid;
  logic              o_ready;
  logic              i_mode;
  logic [63:0]       i_A, i_B;
  logic [TAG_W-1:0]  i_tag;
  logic              o_valid;
  logic              i_ready;
  logic [15:0]       o_large_exp, o_small_exp, o_exp_diff;
  logic [52:0]       o_large_frac53, o_small_frac53;
  logic [1:0]        o_Ls, o_op, o_swap;
  logic [7:0]        o_class_l, o_class_s;
  logic [TAG_W-1:0]  o_tag;
  logic [BW-1:0]     obs;

  logic [BW-1:0] exp_q [$];
  int checks   = 0;
  int errors   = 0;
  int n_pushed = 0;
  int n_popped = 0;

  // Hand-computed vector table.
  logic        t_mode  [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [63:0] t_a     [7] = '{64'h4000000000000000, 64'h3F800000C0000000,
                               64'h7FF0000000000000, 64'h0000000100000001,
                               64'h8000000000000001, 64'h7F80000080000000,
                               64'hFFF0000000000001};
  logic [63:0] t_b     [7] = '{64'h3FF0000000000000, 64'h404000003F800000,
                               64'h7FF8000000000000, 64'h0000000100000001,
                               64'h0020000000000000, 64'hC120000000000000,
                               64'h3FF8000000000000};
  logic [15:0] t_lexp  [7] = '{16'h0400, 16'h8080, 16'h07FF, 16'h0000,
                               16'h0002, 16'hFF00, 16'h07FF};
  logic [15:0] t_sexp  [7] = '{16'h03FF, 16'h7F7F, 16'h07FF, 16'h0000,
                               16'h0000, 16'h8200, 16'h03FF};
  logic [15:0] t_diff  [7] = '{16'h0001, 16'h0101, 16'h0000, 16'h0000,
                               16'h0001, 16'h7D00, 16'h0400};
  logic [52:0] t_lfrac [7] = '{53'h10000000000000, 53'h18000000800000,
                               53'h18000000000000, 53'h00000020000001,
                               53'h10000000000000, 53'h10000000000000,
                               53'h10000000000001};
  logic [52:0] t_sfrac [7] = '{53'h10000000000000, 53'h10000000800000,
                               53'h10000000000000, 53'h00000020000001,
                               53'h00000000000001, 53'h14000000000000,
                               53'h18000000000000};
  logic [1:0]  t_ls    [7] = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3};
  logic [1:0]  t_op    [7] = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd3, 2'd3, 2'd3};
  logic [1:0]  t_swap  [7] = '{2'd0, 2'd2, 2'd3, 2'd0, 2'd3, 2'd0, 2'd0};
  logic [7:0]  t_cl    [7] = '{8'h00, 8'h00, 8'h88, 8'h11, 8'h00, 8'h42, 8'h88};
  logic [7:0]  t_cs    [7] = '{8'h00, 8'h00, 8'h44, 8'h11, 8'h11, 8'h02, 8'h00};

  fp_extract_pipe #(.PIPE_DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_mode         (i_mode),
    .i_A            (i_A),
    .i_B            (i_B),
    .i_tag          (i_tag),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_large_exp    (o_large_exp),
    .o_small_exp    (o_small_exp),
    .o_exp_diff     (o_exp_diff),
    .o_large_frac53 (o_large_frac53),
    .o_small_frac53 (o_small_frac53),
    .o_Ls           (o_Ls),
    .o_op           (o_op),
    .o_swap         (o_swap),
    .o_class_l      (o_class_l),
    .o_class_s      (o_class_s),
    .o_tag          (o_tag)
  );

  assign obs = {o_large_exp, o_small_exp, o_exp_diff, o_large_frac53, o_small_frac53,
                o_Ls, o_op, o_swap, o_class_l, o_class_s, o_tag};

  // Clock
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [BW-1:0] expected(input int v, input logic [TAG_W-1:0] tag);
    logic [7:0] cl, cs;
    cl = CLASS_EN ? t_cl[v] : 8'h00;
    cs = CLASS_EN ? t_cs[v] : 8'h00;
    return {t_lexp[v], t_sexp[v], t_diff[v], t_lfrac[v], t_sfrac[v],
            t_ls[v], t_op[v], t_swap[v], cl, cs, tag};
  endfunction

  // Driver: present one op, wait (bounded) for acceptance, record expectation.
  task automatic send(input int v, input logic [TAG_W-1:0] tag);
    int   budget;
    logic acc;
    budget  = 0;
    acc     = 1'b0;
    i_valid = 1'b1;
    i_mode  = t_mode[v];
    i_A     = t_a[v];
    i_B     = t_b[v];
    i_tag   = tag;
    while (!acc && budget < 50) begin
      @(negedge i_clk);
      acc = o_ready;
      @(posedge i_clk);
      budget++;
    end
    if (acc) begin
      exp_q.push_back(expected(v, tag));
      n_pushed++;
    end else begin
      check("send_timeout", {{(BW-1){1'b0}}, acc}, {{(BW-1){1'b0}}, 1'b1});
    end
    #1;
    i_valid = 1'b0;
  endtask

  // Count negedges from acceptance until o_valid rises.
  task automatic check_latency(input string tag);
    int lat;
    lat = 0;
    while (lat < 20) begin
      @(negedge i_clk);
      lat++;
      if (o_valid) break;
    end
    check(tag, BW'(lat), BW'(DEPTH));
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 200) begin
      @(posedge i_clk);
      budget++;
    end
    check(tag, BW'(exp_q.size()), '0);
  endtask

  // Scoreboard: while o_valid, outputs must equal the queue head (so they
  // also hold during stalls); pop on a completed transfer.
  always @(negedge i_clk) begin
    if (o_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", {{(BW-1){1'b0}}, o_valid}, '0);
      end else begin
        check("result", obs, exp_q[0]);
        if (i_ready) begin
          void'(exp_q.pop_front());
          n_popped++;
        end
      end
    end
  end

  initial begin
    // Reset
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_mode  = 1'b0;
    i_A     = '0;
    i_B     = '0;
    i_tag   = '0;
    i_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_valid", {{(BW-1){1'b0}}, o_valid}, '0);
    check("rst_ready", {{(BW-1){1'b0}}, o_ready}, {{(BW-1){1'b0}}, 1'b1});
    check("rst_outs", obs, '0);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Single op latency on an empty pipe
    send(0, 4'd1);
    check_latency("latency_first");
    @(posedge i_clk);
    #1;

    // Back-to-back directed vectors, alternating modes
    for (int v = 1; v < 7; v++) send(v, TAG_W'(v + 1));
    drain("drain_directed");

    // Backpressure: 8 ops, i_ready low for 5 cycles mid-stream
    @(posedge i_clk);
    #1;
    fork
      begin
        for (int k = 0; k < 8; k++) send(k % 7, TAG_W'(8 + k));
      end
      begin
        repeat (3) @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        repeat (4) @(posedge i_clk);
        @(negedge i_clk);
        check("bp_ready_low", {{(BW-1){1'b0}}, o_ready}, '0);
        @(posedge i_clk);
        #1;
        i_ready = 1'b1;
      end
    join
    drain("drain_bp");
    check("bp_count", BW'(n_popped), BW'(n_pushed));

    // Reset with a full, stalled pipe
    @(posedge i_clk);
    #1;
    i_ready = 1'b0;
    send(2, 4'd3);
    send(5, 4'd4);
    @(negedge i_clk);
    check("full_valid", {{(BW-1){1'b0}}, o_valid}, {{(BW-1){1'b0}}, 1'b1});
    check("full_ready", {{(BW-1){1'b0}}, o_ready}, '0);
    #1;
    i_rst_n = 1'b0;
    #1;
    check("midrst_valid", {{(BW-1){1'b0}}, o_valid}, '0);
    check("midrst_outs", obs, '0);
    check("midrst_ready", {{(BW-1){1'b0}}, o_ready}, {{(BW-1){1'b0}}, 1'b1});
    n_pushed = n_pushed - exp_q.size();
    exp_q.delete();
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    check("postrst_ready", {{(BW-1){1'b0}}, o_ready}, {{(BW-1){1'b0}}, 1'b1});
    send(6, 4'd9);
    check_latency("latency_post_rst");
    drain("drain_post_rst");
    check("total_count", BW'(n_popped), BW'(n_pushed));

    // Report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
